config_chain_loader: RTL
========================

// Module: config_chain_loader
// PURPOSE
//  Host-side driver for the fabric configuration scan chain: serialises config words onto the chain head.
//  Feeds shift_in, cen and set_in of the first config_tile; shifts exactly CHAIN_LEN bits, then pulses set.
//  Also reads the old chain contents back from the chain tail (shift_out of the last tile) for verify.
//  Sits between the management/bus interface and the tile array.
// PARAMETERS
//  WORD_W     32    width of host config words
//  CHAIN_LEN  1024  total config bits in chain (>=1); sum of COMB_N+MEM_N over all tiles
//  CNT_W      $clog2(CHAIN_LEN+1)  bit counter width (derived)
// PORTS
//  clk         in   1       fabric/config clock
//  rst_n       in   1       async active-low reset
//  start       in   1       1-cycle request to begin a load; ignored unless idle
//  word_valid  in   1       host word available
//  word_data   in   WORD_W  host config word
//  word_ready  out  1       loader accepts word_data this cycle (valid&&ready)
//  cen         out  1       chain shift enable (to tile cen)
//  chain_sdo   out  1       serial data to chain head (to tile shift_in)
//  chain_set   out  1       config set pulse (to tile set_in)
//  chain_sdi   in   1       serial data from chain tail (tile shift_out)
//  rb_valid    out  1       1-cycle strobe: rb_data holds a readback word
//  rb_data     out  WORD_W  readback word, same packing as word_data
//  busy        out  1       high from start accept until done
//  done        out  1       1-cycle pulse when load completes
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all outputs 0; bit counter, shift reg, rb reg cleared.
//  FSM: IDLE -> FETCH on start. FETCH: word_ready=1; on valid&&ready load shift reg -> SHIFT.
//   SHIFT: cen=1 every cycle, chain_sdo=shreg[0], shreg>>=1, bit_cnt++ ; per-word count k counts bits.
//   Leave SHIFT when k==WORD_W (-> FETCH) or bit_cnt==CHAIN_LEN (-> SET), evaluated after the bit.
//   SET: chain_set=1 for exactly 1 cycle, cen=0 -> DONE. DONE: done=1 one cycle -> IDLE.
//  Bit order: LSB of each word first; words in arrival order. Final word when CHAIN_LEN%WORD_W!=0:
//   only low CHAIN_LEN%WORD_W bits shifted, upper bits discarded. No extra word is consumed.
//  Total: number of words = ceil(CHAIN_LEN/WORD_W); cen-high cycles == CHAIN_LEN exactly.
//  word_ready is 0 outside FETCH; FETCH waits indefinitely (cen=0, chain holds). 1 bubble cycle
//   per word (FETCH) minimum; no back-to-back streaming requirement.
//  chain_sdo is 0 whenever cen=0. chain_set never coincides with cen.
//  Readback: in each cen cycle sample chain_sdi (tail's current bit, pre-shift) into rb reg at index k.
//   rb_valid pulses the cycle after the last bit of each word (full or final partial);
//   unused upper bits of final partial readback word are 0. rb_valid has no backpressure.
//  busy=1 in FETCH/SHIFT/SET/DONE. start while busy ignored. start and a stray word_valid in IDLE: no word consumed.
//  Reset mid-load: outputs drop immediately; chain is left partially shifted, no set issued;
//   next start restarts from bit 0.
// TESTING
//  T1 WORD_W=8,CHAIN_LEN=16: start, words 0xA5,0x3C -> cen high 16 cycles, sdo=1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; set 1 cycle; done.
//  T2 CHAIN_LEN=12,WORD_W=8: words 0xFF,0x0F -> 12 cen cycles, 2 words consumed, 3rd word_valid never accepted.
//  T3 model chain as 12-bit shift reg preloaded 0xABC: after load rb_data=0xBC then 0x0A, chain holds new bits.
//  T4 hold word_valid low 20 cycles mid-load -> cen=0, busy=1 throughout; resumes with no lost/duplicated bit.
//  T5 assert rst_n=0 during SHIFT bit 5 -> cen/sdo/busy 0 same cycle, no chain_set; new start reloads full chain.
//  T6 start pulse while busy and start in SET cycle -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/config_chain_loader.sv
// Host-side configuration scan-chain loader: serialises host words LSB-first onto the chain head,
// pulses set after exactly CHAIN_LEN shifted bits, and captures the old chain contents from the tail.
module config_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              cen,
  output logic              chain_sdo,
  output logic              chain_set,
  input  logic              chain_sdi,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              done
);

  localparam int KW = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [KW-1:0]    LAST_K   = KW'(WORD_W - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] SET   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] rb_q, rb_d;
  logic              rb_valid_q, rb_valid_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    k_d        = k_q;
    shreg_d    = shreg_q;
    rb_d       = rb_q;
    rb_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bit_cnt_d = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // Readback word is cleared here so unused bits of a final partial word read as 0.
        if (word_valid) begin
          shreg_d = word_data;
          k_d     = '0;
          rb_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        k_d       = k_q + 1'b1;
        rb_d      = rb_q | (WORD_W'(chain_sdi) << k_q);
        // Chain length wins over word boundary so the final partial word ends the load.
        if (bit_cnt_q == LAST_BIT) begin
          rb_valid_d = 1'b1;
          state_d    = SET;
        end else if (k_q == LAST_K) begin
          rb_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end
      SET:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      k_q        <= '0;
      shreg_q    <= '0;
      rb_q       <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      k_q        <= k_d;
      shreg_q    <= shreg_d;
      rb_q       <= rb_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // Strobes decode straight from state so an async reset silences them immediately.
  assign word_ready = (state_q == FETCH);
  assign cen        = (state_q == SHIFT);
  assign chain_sdo  = cen & shreg_q[0];
  assign chain_set  = (state_q == SET);
  assign done       = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign rb_valid   = rb_valid_q;
  assign rb_data    = rb_q;

endmodule
